// File: rtl/xbar_pkg.sv
// Shared crossbar types: port count, source-id width, beat layout and the
// one-hot grant decoder used by the egress endpoint.
package xbar_pkg;

    localparam int XBAR_PORTS = 16;
    localparam int XBAR_SEL_W = 4;
    localparam int XBAR_WIDTH = 8;

    typedef struct packed {
        logic                  valid;
        logic [XBAR_WIDTH-1:0] data;
    } xbar_beat_t;

    typedef logic [XBAR_SEL_W-1:0] xbar_src_t;

    typedef struct packed {
        logic      legal;
        xbar_src_t idx;
    } xbar_dec_t;

    // legal is set only when exactly one grant bit is high
    function automatic xbar_dec_t onehot_to_idx(input logic [XBAR_PORTS-1:0] vec);
        xbar_dec_t res;
        int        cnt;
        res.idx   = '0;
        res.legal = 1'b0;
        cnt       = 0;
        for (int i = 0; i < XBAR_PORTS; i++) begin
            if (vec[i]) begin
                res.idx = xbar_src_t'(i);
                cnt++;
            end
        end
        res.legal = (cnt == 1);
        return res;
    endfunction

endpackage

// File: rtl/xbar_egress_fifo.sv
// First-word-fall-through sync FIFO holding {src, data} entries.
// Read data is forced to zero while empty so the port outputs idle at zero.
module xbar_egress_fifo #(
    parameter int width = 12,
    parameter int depth = 8,
    localparam int AW = $clog2(depth),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign level = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == LW'(depth));
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/xbar_egress_port.sv
// Egress endpoint for one crossbar output: grant decode, FWFT buffering, flush FSM.
// Optional saturating beat/drop counters are built when XBAR_EGRESS_STATS_EN is defined.
//   state    | meaning
//   ST_RUN   | accepting beats and presenting them downstream
//   ST_FLUSH | FIFO held empty, incoming beats ignored
module xbar_egress_port
    import xbar_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 8,
    parameter int ports = 16,
    localparam int LW = $clog2(depth) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [width:0]        xb_data,
    input  logic [XBAR_PORTS-1:0] xb_grant,
    output logic                  xb_ready,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [width-1:0]      m_data,
    output logic [XBAR_SEL_W-1:0] m_src,
    input  logic                  m_ready,
    output logic [LW-1:0]         level,
    output logic                  err_grant,
    output logic                  overflow
`ifdef XBAR_EGRESS_STATS_EN
    ,
    output logic [15:0]           beat_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0] state;
    logic       run;
    logic       flush_entry;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       ovf_evt;
    logic       err_evt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_clear;
    xbar_dec_t  dec;
    logic [XBAR_SEL_W+width-1:0] fifo_dout;

    assign run         = (state == ST_RUN);
    assign flush_entry = run & flush;
    assign fifo_clear  = flush_entry | (state == ST_FLUSH);
    assign dec         = onehot_to_idx(xb_grant);

    assign push_req = xb_data[width] & run;
    assign pop      = m_valid & m_ready;
    // a full FIFO still takes a beat when the head leaves in the same cycle
    assign push     = push_req & dec.legal & (~fifo_full | pop);
    assign ovf_evt  = push_req & dec.legal & fifo_full & ~pop;
    assign err_evt  = push_req & ~dec.legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   state <= flush ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state <= flush ? ST_FLUSH : ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_grant <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush_entry) begin
            err_grant <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (err_evt) err_grant <= 1'b1;
            if (ovf_evt) overflow  <= 1'b1;
        end
    end

    xbar_egress_fifo #(
        .width(XBAR_SEL_W + width),
        .depth(depth)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clear(fifo_clear),
        .push (push),
        .pop  (pop),
        .din  ({dec.idx, xb_data[width-1:0]}),
        .dout (fifo_dout),
        .level(level),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign m_valid  = run & ~fifo_empty;
    assign m_data   = fifo_dout[width-1:0];
    assign m_src    = fifo_dout[XBAR_SEL_W+width-1:width];
    assign xb_ready = run & ~fifo_full;

`ifdef XBAR_EGRESS_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            drop_cnt <= '0;
        end else if (flush_entry) begin
            beat_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && beat_cnt != 16'hFFFF)                 beat_cnt <= beat_cnt + 16'd1;
            if ((ovf_evt || err_evt) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xbar_egress_port.sv
// Directed bench for xbar_egress_port: transfer, back-pressure, full push/pop,
// bad grants, flush and asynchronous reset. Optional stats checked when XBAR_EGRESS_STATS_EN is set.
module tb_xbar_egress_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  xb_data;
    logic [15:0] xb_grant;
    logic        xb_ready;
    logic        flush;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [3:0]  m_src;
    logic        m_ready;
    logic [3:0]  level;
    logic        err_grant;
    logic        overflow;
`ifdef XBAR_EGRESS_STATS_EN
    logic [15:0] beat_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbar_egress_port #(.width(8), .depth(8), .ports(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .xb_data  (xb_data),
        .xb_grant (xb_grant),
        .xb_ready (xb_ready),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_src    (m_src),
        .m_ready  (m_ready),
        .level    (level),
        .err_grant(err_grant),
        .overflow (overflow)
`ifdef XBAR_EGRESS_STATS_EN
        ,
        .beat_cnt (beat_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input int g);
        xb_data  = {1'b1, d};
        xb_grant = 16'h0001 << g;
        cyc();
        xb_data  = '0;
        xb_grant = '0;
    endtask

    initial begin
        rst = 1'b0; xb_data = '0; xb_grant = '0; flush = 1'b0; m_ready = 1'b0;
        #2;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_src", m_src, 0);
        chk("rst_level", level, 0);
        chk("rst_err", err_grant, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_xb_ready", xb_ready, 1);
        #10 rst = 1'b1;
        cyc();

        // single beat, then drain
        xb_data = 9'h1AA; xb_grant = 16'h0004;
        cyc();
        xb_data = '0; xb_grant = '0;
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_data", m_data, 8'hAA);
        chk("t1_m_src", m_src, 2);
        chk("t1_level", level, 1);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        chk("t1_drain_level", level, 0);
        chk("t1_drain_valid", m_valid, 0);

        // back-pressure fill and overflow
        for (int i = 0; i < 8; i++) beat(8'(i), 5);
        chk("t2_level8", level, 8);
        chk("t2_xb_ready", xb_ready, 0);
        chk("t2_ovf_pre", overflow, 0);
        beat(8'h08, 5);
        chk("t2_ovf", overflow, 1);
        chk("t2_level_after_drop", level, 8);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_valid%0d", i), m_valid, 1);
            chk($sformatf("t2_data%0d", i), m_data, i);
            chk($sformatf("t2_src%0d", i), m_src, 5);
            cyc();
        end
        m_ready = 1'b0;
        chk("t2_empty", level, 0);
        chk("t2_ovf_sticky", overflow, 1);

        // flush pulse to clear the sticky overflow
        flush = 1'b1; cyc(); flush = 1'b0; cyc();
        chk("t3_ovf_cleared", overflow, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) beat(8'h10 + 8'(i), 1);
        chk("t3_level8", level, 8);
        m_ready = 1'b1;
        beat(8'h55, 1);
        m_ready = 1'b0;
        chk("t3_level_kept", level, 8);
        chk("t3_ovf_zero", overflow, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t3_data%0d", i), m_data, 8'h11 + i);
            cyc();
        end
        chk("t3_data_55", m_data, 8'h55);
        chk("t3_src_55", m_src, 1);
        cyc();
        m_ready = 1'b0;
        chk("t3_empty", level, 0);

        // bad grants
        chk("t4_err_pre", err_grant, 0);
        xb_data = 9'h133; xb_grant = 16'h0003;
        cyc();
        chk("t4_err_multi", err_grant, 1);
        chk("t4_level_multi", level, 0);
        xb_data = 9'h144; xb_grant = 16'h0000;
        cyc();
        xb_data = '0;
        chk("t4_err_zero", err_grant, 1);
        chk("t4_level_zero", level, 0);
        chk("t4_valid", m_valid, 0);

        // flush with traffic arriving
        for (int i = 0; i < 4; i++) beat(8'h20 + 8'(i), 0);
        chk("t5_level4", level, 4);
        flush = 1'b1; xb_data = 9'h177; xb_grant = 16'h0008;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk($sformatf("t5_level%0d", i), level, 0);
            chk($sformatf("t5_valid%0d", i), m_valid, 0);
            chk($sformatf("t5_xb_ready%0d", i), xb_ready, 0);
            chk($sformatf("t5_err%0d", i), err_grant, 0);
            chk($sformatf("t5_ovf%0d", i), overflow, 0);
        end
        flush = 1'b0; xb_data = '0; xb_grant = '0;
        cyc();
        chk("t5_run_ready", xb_ready, 1);
        chk("t5_run_level", level, 0);
        beat(8'h0F, 15);
        chk("t5_valid", m_valid, 1);
        chk("t5_data", m_data, 8'h0F);
        chk("t5_src", m_src, 15);
        chk("t5_level1", level, 1);
`ifdef XBAR_EGRESS_STATS_EN
        chk("t5_beat_cnt", beat_cnt, 1);
        chk("t5_drop_cnt", drop_cnt, 0);
`endif

        // async reset mid-stream
        beat(8'h31, 4);
        beat(8'h32, 4);
        chk("t6_level3", level, 3);
        xb_data = 9'h199; xb_grant = 16'h0010;
        #3 rst = 1'b0;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_data", m_data, 0);
        chk("t6_rst_src", m_src, 0);
        chk("t6_rst_ready", xb_ready, 1);
`ifdef XBAR_EGRESS_STATS_EN
        chk("t6_beat_cnt", beat_cnt, 0);
`endif
        xb_data = '0; xb_grant = '0;
        #10 rst = 1'b1;
        cyc(); cyc();
        chk("t6_post_valid", m_valid, 0);
        chk("t6_post_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_egress_port.md
Name: xbar_egress_port

Overview:
- Output-side endpoint for one crossbar16x16 output port.
- Receives the crossbar's {valid,data} beat plus the one-hot grant vector and recovers the 4-bit source id.
- Buffers beats in a depth-entry FIFO and presents them on a ready/valid stream to the downstream consumer.
- Reports back-pressure (xb_ready), grant errors and overflow; a flush FSM empties the port on command.

Parameters:
- width, 8: data bits per beat.
- depth, 8: FIFO entries; must be a power of 2 and at least 2.
- ports, 16: crossbar input count; fixed at 16, giving a 4-bit source id.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- xb_data  in  width+1  crossbar output beat; bit [width] = valid, bits [width-1:0] = payload.
- xb_grant  in  16  one-hot grant vector for this output; bit i set means input i won arbitration.
- xb_ready  out  1  the port can take a beat this cycle.
- flush  in  1  level request to discard all buffered data.
- m_valid  out  1  downstream beat valid.
- m_data  out  width  downstream payload.
- m_src  out  4  source input index of the m_data beat.
- m_ready  in  1  downstream accept.
- level  out  $clog2(depth)+1  current FIFO occupancy.
- err_grant  out  1  sticky: a valid beat arrived with a grant that was not one-hot.
- overflow  out  1  sticky: a valid beat was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied and state=RUN.
  - m_valid=0, m_data=0, m_src=0, level=0, err_grant=0, overflow=0, xb_ready=1.
- Transfer definitions:
  - push_req = xb_data[width] & (state==RUN).
  - pop = m_valid & m_ready.
- Grant decode: the src id is the index of the single set bit in xb_grant.
  - If push_req and xb_grant is zero or has more than one bit set: the beat is dropped and err_grant is set the next cycle.
  - Grant checking is skipped when valid=0.
- Accept rule: a push is accepted when push_req, the grant is legal, and (level<depth or pop in the same cycle).
  - Full with a simultaneous pop: push accepted, level unchanged.
  - Full without a pop: beat dropped and overflow set.
- xb_ready = (state==RUN) & (level<depth); it is combinational from registered state.
- FIFO is first-word-fall-through:
  - A beat written at edge N is visible on m_data/m_src with m_valid=1 after edge N, so latency is 1 cycle.
  - m_data/m_src hold stable while m_valid=1 and m_ready=0.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo depth.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH when flush=1, taken at that edge.
  - FLUSH: pointers and level cleared; m_valid=0; xb_ready=0; incoming beats ignored and not counted as overflow or grant errors.
  - FLUSH -> RUN on the first edge where flush=0.
  - err_grant and overflow clear on entry to FLUSH.
- Sticky flags change only when set by their event, on entry to FLUSH, or on reset.
- Reset asserted mid-transfer: all state is cleared immediately with no partial beat retained. The downstream must treat the m_valid drop as abort.

Optional Feature:
- Macro XBAR_EGRESS_STATS_EN.
- When defined, adds two outputs:
  - beat_cnt (16 bit): counts accepted pushes.
  - drop_cnt (16 bit): counts beats dropped for overflow or bad grant.
- Both counters saturate at 16'hFFFF and clear on reset and on FLUSH entry.
- When undefined, neither port nor any counter logic exists.

Decomposition:
- Shared package xbar_pkg holds:
  - XBAR_PORTS=16 and XBAR_SEL_W=4.
  - typedef xbar_beat_t = {valid, data[width-1:0]}.
  - typedef xbar_src_t = logic [3:0].
  - The onehot_to_idx function, which returns index plus a legal flag.
- One sub-module, xbar_egress_fifo: FWFT sync FIFO of {src, data} with push/pop/level/full/clear, parameterised by depth.
- The FSM, grant decode and flags live in the top level.

Test Plan:
- Reset then single beat: xb_data=9'h1AA, grant=16'h0004 -> next cycle m_valid=1, m_data=8'hAA, m_src=2, level=1. With m_ready=1 it drains to level=0.
- Back-pressure fill: m_ready=0, push 9 beats 8'h00..8'h08 with grant bit 5.
  - After 8 beats: xb_ready=0.
  - 9th beat: dropped, overflow=1.
  - Then m_ready=1: outputs 00..07 in order, all with m_src=5.
- Full plus simultaneous push/pop: level=8, m_ready=1, push 8'h55 in the same cycle -> level stays 8, overflow stays 0, and 8'h55 emerges 8th in order.
- Bad grant: valid beat with grant=16'h0003, then a beat with grant=16'h0000 -> both dropped, err_grant=1, level unchanged.
- Flush: 4 buffered beats, flush=1 for 2 cycles while valid beats arrive -> level=0, m_valid=0, flags clear. Once flush=0, grant bit 15 with 8'h0F gives m_src=15.
- Async reset mid-stream: drop rst between clock edges with level=3 -> outputs reset immediately, no beats appear after release. With XBAR_EGRESS_STATS_EN defined, beat_cnt=0.
